// File: rtl/elevator_controller_if.sv
// Request/status bundle between the elevator controller and its consumers.
// Carries the estop input only when ESTOP_EN is defined.
interface elevator_controller_if;
   logic [4:0] req;
   logic [2:0] floor;
   logic       hold;
   logic       moving;
   logic       dir_up;
   logic [4:0] pending;
`ifdef ESTOP_EN
   logic       estop;

   modport master (input req, input estop,
                   output floor, output hold, output moving, output dir_up, output pending);
   modport slave  (output req, output estop,
                   input floor, input hold, input moving, input dir_up, input pending);
`else
   modport master (input req,
                   output floor, output hold, output moving, output dir_up, output pending);
   modport slave  (output req,
                   input floor, input hold, input moving, input dir_up, input pending);
`endif
endinterface

// File: rtl/elevator_controller.sv
// SCAN-ordered car-motion sequencer: latches requests, times travel and door hold.
// Optional emergency stop (HALT state, estop port) enabled by defining ESTOP_EN.
module elevator_controller #(
   parameter int unsigned NUM_FLOORS    = 5,
   parameter int unsigned TRAVEL_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES   = 3
) (
   input logic                   clk,
   input logic                   rst_n,
   elevator_controller_if.master bus
);

   localparam int unsigned CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int unsigned CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
   localparam logic [CW-1:0] TRAV_LOAD  = CW'(TRAVEL_CYCLES - 1);
   localparam logic [CW-1:0] DOOR_LOAD  = CW'(DOOR_CYCLES - 1);
   localparam logic [4:0]    VALID_MASK = 5'((1 << NUM_FLOORS) - 1);

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      DOOR
`ifdef ESTOP_EN
      , HALT
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    floor_q, floor_d, nxt_floor;
   logic          dir_q, dir_d;
   logic [4:0]    pend_q, pend_d, pend_in;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hold_q, hold_d, moving_q, moving_d;
   logic [4:0]    above, below, cur_bit, nxt_bit;
   logic          up_any, dn_any;

   // Requests arriving on this edge take part in this edge's decision.
   always_comb begin
      above = '0;
      below = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (i > 32'(floor_q)) above[i] = 1'b1;
         if (i < 32'(floor_q)) below[i] = 1'b1;
      end
      pend_in   = pend_q | (bus.req & VALID_MASK);
      cur_bit   = 5'd1 << floor_q;
      nxt_floor = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
      nxt_bit   = 5'd1 << nxt_floor;
      up_any    = |(pend_in & above);
      dn_any    = |(pend_in & below);
   end

   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      dir_d   = dir_q;
      pend_d  = pend_in;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|(pend_in & cur_bit)) begin
               state_d = DOOR;
               pend_d  = pend_in & ~cur_bit;
               cnt_d   = DOOR_LOAD;
            end else if (up_any) begin
               state_d = MOVE;
               dir_d   = 1'b1;
               cnt_d   = TRAV_LOAD;
            end else if (dn_any) begin
               state_d = MOVE;
               dir_d   = 1'b0;
               cnt_d   = TRAV_LOAD;
            end
         end
         MOVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               floor_d = nxt_floor;
               if (|(pend_in & nxt_bit)) begin
                  state_d = DOOR;
                  pend_d  = pend_in & ~nxt_bit;
                  cnt_d   = DOOR_LOAD;
               end else begin
                  cnt_d = TRAV_LOAD;
               end
            end
         end
         DOOR: begin
            if (|(pend_in & cur_bit)) begin
               pend_d = pend_in & ~cur_bit;
               cnt_d  = DOOR_LOAD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (dir_q ? up_any : dn_any) begin
               state_d = MOVE;
               cnt_d   = TRAV_LOAD;
            end else if (dir_q ? dn_any : up_any) begin
               state_d = MOVE;
               dir_d   = ~dir_q;
               cnt_d   = TRAV_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
`ifdef ESTOP_EN
         HALT: state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
`ifdef ESTOP_EN
      if (bus.estop) begin
         state_d = HALT;
         floor_d = floor_q;
         dir_d   = dir_q;
         pend_d  = '0;
         cnt_d   = cnt_q;
      end
`endif
      hold_d   = (state_d == DOOR);
      moving_d = (state_d == MOVE);
`ifdef ESTOP_EN
      if (state_d == HALT) hold_d = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         floor_q  <= '0;
         dir_q    <= 1'b1;
         pend_q   <= '0;
         cnt_q    <= '0;
         hold_q   <= 1'b0;
         moving_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         dir_q    <= dir_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         moving_q <= moving_d;
      end
   end

   assign bus.floor   = floor_q;
   assign bus.hold    = hold_q;
   assign bus.moving  = moving_q;
   assign bus.dir_up  = dir_q;
   assign bus.pending = pend_q;

endmodule
